// File: rtl/uart_receiver_command_control_if.sv
// Signal bundle between the command receiver and its neighbours: serial input,
// received-byte strobes and the decoded command outputs.
interface uart_receiver_command_control_if;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_FERROR;
    logic       start_transmission;
    logic       stop_transmission;
    logic [3:0] refresh_rate;
    logic       cmd_error;

    modport master (
        input  RxD,
        output Rx_DATA, Rx_VALID, Rx_FERROR,
        output start_transmission, stop_transmission, refresh_rate, cmd_error
    );

    modport slave (
        output RxD,
        input  Rx_DATA, Rx_VALID, Rx_FERROR,
        input  start_transmission, stop_transmission, refresh_rate, cmd_error
    );
endinterface

// File: rtl/uart_receiver_command_control.sv
// Oversampled 8N1 receiver plus a small ASCII command parser (S<CR>, P<CR>, R<d><CR>)
// that drives the sensor printout start/stop pulses and the refresh-rate code.
module uart_receiver_command_control #(
    parameter logic [15:0] CLKS_PER_BIT    = 16'd868,
    parameter logic [3:0]  REFRESH_DEFAULT = 4'd1
) (
    input  logic clk,
    input  logic reset,
    uart_receiver_command_control_if.master bus
);
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_S, P_P, P_R, P_RD, P_ERR} p_state_t;

    localparam logic [15:0] HALF_BIT  = CLKS_PER_BIT >> 1;
    localparam logic [15:0] LAST_TICK = CLKS_PER_BIT - 16'd1;

    logic       rx_meta, rxs, rx_prev;
    rx_state_t  rx_state, rx_next;
    logic [15:0] baud_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg, rx_data_q;
    logic       rx_valid_q, rx_ferror_q;
    logic       half_tick, full_tick, counting, sample_bit, frame_ok, frame_bad;

    p_state_t   p_state, p_next;
    logic [3:0] pending_q, rate_q;
    logic       start_q, stop_q, err_q;
    logic       is_cr, is_digit, start_d, stop_d, err_d, load_pending, load_rate;

    // Synchroniser and edge history reset to the idle-high line level so reset
    // release never looks like a start bit.
    // NOTE: every clocked process uses <= so all flops see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.RxD;
            rxs     <= rx_meta;
            rx_prev <= rxs;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    assign half_tick = (baud_cnt == HALF_BIT);
    assign full_tick = (baud_cnt == LAST_TICK);

    // NOTE: next-state defaults to the current state so no path infers a latch.
    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (rx_prev && !rxs)         rx_next = RX_START;
            RX_START: if (half_tick)               rx_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_tick && bit_cnt == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (full_tick)               rx_next = rxs ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (rxs)                     rx_next = RX_IDLE;
            default:                               rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        counting   = (rx_state == RX_START) || (rx_state == RX_DATA) || (rx_state == RX_STOP);
        sample_bit = (rx_state == RX_DATA) && full_tick;
        frame_ok   = (rx_state == RX_STOP) && full_tick && rxs;
        frame_bad  = (rx_state == RX_STOP) && full_tick && !rxs;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ferror_q <= 1'b0;
        end else begin
            rx_valid_q  <= frame_ok;
            rx_ferror_q <= frame_bad;
            if (!counting || rx_state != rx_next || full_tick) baud_cnt <= '0;
            else                                               baud_cnt <= baud_cnt + 16'd1;
            if (rx_state != RX_DATA)                bit_cnt <= '0;
            else if (sample_bit && bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
            if (sample_bit) shift_reg <= {rxs, shift_reg[7:1]};
            if (frame_ok)   rx_data_q <= shift_reg;
        end
    end

    // Parser: moves only on received-byte or framing-error strobes.
    assign is_cr    = (rx_data_q == 8'h0D);
    assign is_digit = (rx_data_q >= 8'h30) && (rx_data_q <= 8'h39);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) p_state <= P_IDLE;
        else       p_state <= p_next;
    end

    always_comb begin
        p_next = p_state;
        if (rx_ferror_q) begin
            p_next = P_ERR;
        end else if (rx_valid_q) begin
            unique case (p_state)
                P_IDLE: begin
                    unique case (rx_data_q)
                        8'h53:        p_next = P_S;
                        8'h50:        p_next = P_P;
                        8'h52:        p_next = P_R;
                        8'h0A, 8'h0D: p_next = P_IDLE;
                        default:      p_next = P_ERR;
                    endcase
                end
                P_S, P_P: p_next = is_cr    ? P_IDLE : P_ERR;
                P_R:      p_next = is_digit ? P_RD   : P_ERR;
                P_RD:     p_next = is_cr    ? P_IDLE : P_ERR;
                P_ERR:    p_next = is_cr    ? P_IDLE : P_ERR;
                default:  p_next = P_IDLE;
            endcase
        end
    end

    // Errors are reported on entry to P_ERR only, so a noisy line yields one pulse.
    always_comb begin
        err_d        = (p_next == P_ERR) && (p_state != P_ERR);
        start_d      = rx_valid_q && (p_state == P_S)  && is_cr;
        stop_d       = rx_valid_q && (p_state == P_P)  && is_cr;
        load_pending = rx_valid_q && (p_state == P_R)  && is_digit;
        load_rate    = rx_valid_q && (p_state == P_RD) && is_cr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            rate_q    <= REFRESH_DEFAULT;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            start_q <= start_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
            // ASCII digits 0x30-0x39 carry their value in the low nibble.
            if (load_pending) pending_q <= rx_data_q[3:0];
            if (load_rate)    rate_q    <= pending_q;
        end
    end

    assign bus.Rx_DATA            = rx_data_q;
    assign bus.Rx_VALID           = rx_valid_q;
    assign bus.Rx_FERROR          = rx_ferror_q;
    assign bus.start_transmission = start_q;
    assign bus.stop_transmission  = stop_q;
    assign bus.refresh_rate       = rate_q;
    assign bus.cmd_error          = err_q;
endmodule

// File: tb/tb_uart_receiver_command_control.sv
// Directed bench for the UART command receiver at 16 clk/bit: byte reception,
// command decoding, error recovery, glitch/break handling and mid-frame reset.
module tb_uart_receiver_command_control;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_receiver_command_control_if bus();

    uart_receiver_command_control #(
        .CLKS_PER_BIT   (16'd16),
        .REFRESH_DEFAULT(4'd1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Event monitor: counts pulses and remembers the cycle each last occurred.
    int cyc = 0;
    int cnt_valid = 0, cnt_ferr = 0, cnt_start = 0, cnt_stop = 0, cnt_err = 0, excl_viol = 0;
    int cyc_valid = 0, cyc_ferr = 0, cyc_start = 0, cyc_stop = 0, cyc_err = 0, cyc_rate = 0;
    logic [3:0] prev_rate = 4'd1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.Rx_VALID === 1'b1)           begin cnt_valid++; cyc_valid = cyc; end
        if (bus.Rx_FERROR === 1'b1)          begin cnt_ferr++;  cyc_ferr  = cyc; end
        if (bus.start_transmission === 1'b1) begin cnt_start++; cyc_start = cyc; end
        if (bus.stop_transmission === 1'b1)  begin cnt_stop++;  cyc_stop  = cyc; end
        if (bus.cmd_error === 1'b1)          begin cnt_err++;   cyc_err   = cyc; end
        if ((int'(bus.start_transmission) + int'(bus.stop_transmission) + int'(bus.cmd_error)) > 1)
            excl_viol++;
        if (bus.refresh_rate !== prev_rate) begin
            cyc_rate  = cyc;
            prev_rate = bus.refresh_rate;
        end
    end

    task automatic drive_bit(input logic b);
        bus.RxD = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop_bit);
    endtask

    task automatic idle_bits(input int n);
        bus.RxD = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic test_reset;
        bus.RxD = 1'b1;
        reset   = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (bus.Rx_DATA !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", bus.Rx_DATA); end
        n_cmp++; if (bus.refresh_rate !== 4'd1) begin n_bad++; $display("FAIL reset_rate: got %0d want 1", bus.refresh_rate); end
        n_cmp++;
        if ({bus.Rx_VALID, bus.Rx_FERROR, bus.start_transmission, bus.stop_transmission, bus.cmd_error} !== 5'b0) begin
            n_bad++; $display("FAIL reset_pulses: got %b want 00000",
                {bus.Rx_VALID, bus.Rx_FERROR, bus.start_transmission, bus.stop_transmission, bus.cmd_error});
        end
    endtask

    task automatic test_bytes;
        int v0, f0;
        v0 = cnt_valid; f0 = cnt_ferr;
        send_frame(8'hA5, 1'b1);
        n_cmp++; if (cnt_valid - v0 !== 1) begin n_bad++; $display("FAIL a5_valid_count: got %0d want 1", cnt_valid - v0); end
        n_cmp++; if (bus.Rx_DATA !== 8'hA5) begin n_bad++; $display("FAIL a5_data: got %h want a5", bus.Rx_DATA); end
        send_frame(8'h00, 1'b1);
        n_cmp++; if (bus.Rx_DATA !== 8'h00) begin n_bad++; $display("FAIL b2b_00_data: got %h want 00", bus.Rx_DATA); end
        send_frame(8'hFF, 1'b1);
        n_cmp++; if (bus.Rx_DATA !== 8'hFF) begin n_bad++; $display("FAIL b2b_ff_data: got %h want ff", bus.Rx_DATA); end
        n_cmp++; if (cnt_valid - v0 !== 3) begin n_bad++; $display("FAIL b2b_valid_count: got %0d want 3", cnt_valid - v0); end
        n_cmp++; if (cnt_ferr - f0 !== 0) begin n_bad++; $display("FAIL bytes_ferr: got %0d want 0", cnt_ferr - f0); end
        // The line is now in P_ERR because 0xA5 is not a command; CR clears it.
        send_frame(8'h0D, 1'b1);
        idle_bits(1);
    endtask

    task automatic test_start_stop;
        int s0, p0, e0;
        s0 = cnt_start; p0 = cnt_stop; e0 = cnt_err;
        send_frame(8'h53, 1'b1);
        send_frame(8'h0D, 1'b1);
        n_cmp++; if (cnt_start - s0 !== 1) begin n_bad++; $display("FAIL start_count: got %0d want 1", cnt_start - s0); end
        n_cmp++; if (cyc_start - cyc_valid !== 1) begin n_bad++; $display("FAIL start_latency: got %0d want 1", cyc_start - cyc_valid); end
        send_frame(8'h50, 1'b1);
        send_frame(8'h0D, 1'b1);
        n_cmp++; if (cnt_stop - p0 !== 1) begin n_bad++; $display("FAIL stop_count: got %0d want 1", cnt_stop - p0); end
        n_cmp++; if (cyc_stop - cyc_valid !== 1) begin n_bad++; $display("FAIL stop_latency: got %0d want 1", cyc_stop - cyc_valid); end
        n_cmp++; if (cnt_err - e0 !== 0) begin n_bad++; $display("FAIL startstop_err: got %0d want 0", cnt_err - e0); end
        n_cmp++; if (cnt_start - s0 !== 1) begin n_bad++; $display("FAIL start_after_p: got %0d want 1", cnt_start - s0); end
        idle_bits(1);
    endtask

    task automatic test_refresh_rate;
        int e0, s0;
        send_frame(8'h52, 1'b1);
        send_frame(8'h37, 1'b1);
        n_cmp++; if (bus.refresh_rate !== 4'd1) begin n_bad++; $display("FAIL rate_before_cr: got %0d want 1", bus.refresh_rate); end
        send_frame(8'h0D, 1'b1);
        n_cmp++; if (bus.refresh_rate !== 4'd7) begin n_bad++; $display("FAIL rate_set7: got %0d want 7", bus.refresh_rate); end
        n_cmp++; if (cyc_rate - cyc_valid !== 1) begin n_bad++; $display("FAIL rate_latency: got %0d want 1", cyc_rate - cyc_valid); end
        e0 = cnt_err;
        send_frame(8'h52, 1'b1);
        send_frame(8'h58, 1'b1);
        send_frame(8'h0D, 1'b1);
        n_cmp++; if (cnt_err - e0 !== 1) begin n_bad++; $display("FAIL rx_err_count: got %0d want 1", cnt_err - e0); end
        n_cmp++; if (bus.refresh_rate !== 4'd7) begin n_bad++; $display("FAIL rx_rate_kept: got %0d want 7", bus.refresh_rate); end
        e0 = cnt_err; s0 = cnt_start;
        send_frame(8'h52, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h51, 1'b1);
        send_frame(8'h53, 1'b1);
        send_frame(8'h0D, 1'b1);
        n_cmp++; if (cnt_err - e0 !== 1) begin n_bad++; $display("FAIL r3q_err_count: got %0d want 1", cnt_err - e0); end
        n_cmp++; if (cnt_start - s0 !== 0) begin n_bad++; $display("FAIL r3q_no_start: got %0d want 0", cnt_start - s0); end
        n_cmp++; if (bus.refresh_rate !== 4'd7) begin n_bad++; $display("FAIL r3q_rate_kept: got %0d want 7", bus.refresh_rate); end
        idle_bits(1);
    endtask

    task automatic test_framing_error;
        int f0, e0, v0, s0;
        f0 = cnt_ferr; e0 = cnt_err; v0 = cnt_valid;
        send_frame(8'h53, 1'b0);
        idle_bits(1);
        n_cmp++; if (cnt_ferr - f0 !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", cnt_ferr - f0); end
        n_cmp++; if (cnt_valid - v0 !== 0) begin n_bad++; $display("FAIL ferr_no_valid: got %0d want 0", cnt_valid - v0); end
        n_cmp++; if (bus.Rx_DATA !== 8'h0D) begin n_bad++; $display("FAIL ferr_data_kept: got %h want 0d", bus.Rx_DATA); end
        n_cmp++; if (cnt_err - e0 !== 1) begin n_bad++; $display("FAIL ferr_cmd_err: got %0d want 1", cnt_err - e0); end
        n_cmp++; if (cyc_err - cyc_ferr !== 1) begin n_bad++; $display("FAIL ferr_err_latency: got %0d want 1", cyc_err - cyc_ferr); end
        s0 = cnt_start;
        send_frame(8'h0D, 1'b1);
        send_frame(8'h53, 1'b1);
        send_frame(8'h0D, 1'b1);
        n_cmp++; if (cnt_start - s0 !== 1) begin n_bad++; $display("FAIL ferr_recover_start: got %0d want 1", cnt_start - s0); end
        idle_bits(1);
    endtask

    task automatic test_glitch_break;
        int v0, f0, e0, s0;
        v0 = cnt_valid; f0 = cnt_ferr; e0 = cnt_err;
        bus.RxD = 1'b0;
        repeat (6) @(negedge clk);
        idle_bits(3);
        n_cmp++; if (cnt_valid - v0 !== 0) begin n_bad++; $display("FAIL glitch_valid: got %0d want 0", cnt_valid - v0); end
        n_cmp++; if (cnt_ferr - f0 !== 0) begin n_bad++; $display("FAIL glitch_ferr: got %0d want 0", cnt_ferr - f0); end
        n_cmp++; if (cnt_err - e0 !== 0) begin n_bad++; $display("FAIL glitch_cmd_err: got %0d want 0", cnt_err - e0); end
        bus.RxD = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        idle_bits(2);
        n_cmp++; if (cnt_ferr - f0 !== 1) begin n_bad++; $display("FAIL break_ferr: got %0d want 1", cnt_ferr - f0); end
        n_cmp++; if (cnt_valid - v0 !== 0) begin n_bad++; $display("FAIL break_valid: got %0d want 0", cnt_valid - v0); end
        s0 = cnt_start;
        send_frame(8'h0D, 1'b1);
        send_frame(8'h53, 1'b1);
        send_frame(8'h0D, 1'b1);
        n_cmp++; if (cnt_start - s0 !== 1) begin n_bad++; $display("FAIL break_recover_start: got %0d want 1", cnt_start - s0); end
        idle_bits(1);
    endtask

    task automatic test_mid_frame_reset;
        int v0;
        logic [7:0] d;
        d = 8'h96;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        bus.RxD = d[4];
        repeat (CPB / 2) @(negedge clk);
        #2 reset = 1'b1;
        bus.RxD = 1'b1;
        #1;
        n_cmp++; if (bus.Rx_DATA !== 8'h00) begin n_bad++; $display("FAIL midreset_data: got %h want 00", bus.Rx_DATA); end
        n_cmp++; if (bus.refresh_rate !== 4'd1) begin n_bad++; $display("FAIL midreset_rate: got %0d want 1", bus.refresh_rate); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        v0 = cnt_valid;
        idle_bits(12);
        n_cmp++; if (cnt_valid - v0 !== 0) begin n_bad++; $display("FAIL midreset_no_valid: got %0d want 0", cnt_valid - v0); end
        send_frame(8'h3C, 1'b1);
        n_cmp++; if (bus.Rx_DATA !== 8'h3C) begin n_bad++; $display("FAIL midreset_next_data: got %h want 3c", bus.Rx_DATA); end
        n_cmp++; if (cnt_valid - v0 !== 1) begin n_bad++; $display("FAIL midreset_next_valid: got %0d want 1", cnt_valid - v0); end
        idle_bits(1);
    endtask

    initial begin
        test_reset();
        test_bytes();
        test_start_stop();
        test_refresh_rate();
        test_framing_error();
        test_glitch_break();
        test_mid_frame_reset();
        n_cmp++; if (excl_viol !== 0) begin n_bad++; $display("FAIL pulse_exclusive: got %0d want 0", excl_viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
